// File: rtl/switch_scheduler.sv
// switch_scheduler: per-output round-robin packet scheduler for the 4-port switch.
// Each output locks to its winning input for one header plus L payload words.
module switch_scheduler #(
  parameter int NPORTS = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [NPORTS-1:0][31:0] in_data,
  input  logic [NPORTS-1:0]       in_valid,
  output logic [NPORTS-1:0]       in_ready,
  output logic [NPORTS-1:0][31:0] outp,
  output logic [NPORTS-1:0]       out_ram_wr,
  output logic [CNT_W-1:0]        total_time,
  output logic                    busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e            state_q [NPORTS];
  state_e            state_d [NPORTS];
  logic [1:0]        owner_q [NPORTS];
  logic [1:0]        owner_d [NPORTS];
  logic [7:0]        rem_q   [NPORTS];
  logic [7:0]        rem_d   [NPORTS];
  logic [1:0]        rr_q    [NPORTS];
  logic [1:0]        rr_d    [NPORTS];
  logic [1:0]        win_s   [NPORTS];
  logic [1:0]        src_s   [NPORTS];
  logic [NPORTS-1:0] owned_s;
  logic [NPORTS-1:0] win_v_s;
  logic [NPORTS-1:0] acc_s;
  logic [1:0]        idx_s;
  logic              cand_s;

  // Ownership snapshot, IDLE arbitration, accept/ready decode and busy flag
  always_comb begin
    owned_s  = '0;
    win_v_s  = '0;
    acc_s    = '0;
    in_ready = '0;
    idx_s    = 2'd0;
    cand_s   = 1'b0;
    busy     = (|in_valid) | (|out_ram_wr);
    for (int o = 0; o < NPORTS; o++) begin
      win_s[o] = rr_q[o];
      src_s[o] = rr_q[o];
      busy     = busy | (state_q[o] == BUSY);
      for (int i = 0; i < NPORTS; i++) begin
        owned_s[i] = owned_s[i] | ((state_q[o] == BUSY) && (owner_q[o] == 2'(i)));
      end
    end
    // An owned input is hidden from every other output's search
    for (int o = 0; o < NPORTS; o++) begin
      for (int k = 0; k < NPORTS; k++) begin
        idx_s      = rr_q[o] + 2'(k);
        cand_s     = (state_q[o] == IDLE) && in_valid[idx_s] &&
                     (in_data[idx_s][1:0] == 2'(o)) && !owned_s[idx_s] && !win_v_s[o];
        win_s[o]   = cand_s ? idx_s : win_s[o];
        win_v_s[o] = win_v_s[o] | cand_s;
      end
    end
    for (int o = 0; o < NPORTS; o++) begin
      src_s[o] = (state_q[o] == BUSY) ? owner_q[o] : win_s[o];
      acc_s[o] = (state_q[o] == BUSY) ? in_valid[owner_q[o]] : win_v_s[o];
      in_ready[src_s[o]] = in_ready[src_s[o]] | (((state_q[o] == BUSY) | win_v_s[o]) & ~reset);
    end
  end

  // Per-output lock FSM next state
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rem_d[o]   = rem_q[o];
      rr_d[o]    = rr_q[o];
      case (state_q[o])
        IDLE: begin
          if (win_v_s[o]) begin
            rr_d[o] = win_s[o] + 2'd1;
            if (in_data[win_s[o]][11:4] != 8'd0) begin
              state_d[o] = BUSY;
              owner_d[o] = win_s[o];
              rem_d[o]   = in_data[win_s[o]][11:4];
            end else begin
              state_d[o] = IDLE;
            end
          end else begin
            state_d[o] = IDLE;
          end
        end
        BUSY: begin
          if (in_valid[owner_q[o]]) begin
            rem_d[o] = rem_q[o] - 8'd1;
            if (rem_q[o] == 8'd1) begin
              state_d[o] = IDLE;
            end else begin
              state_d[o] = BUSY;
            end
          end else begin
            state_d[o] = BUSY;
          end
        end
        default: begin
          state_d[o] = IDLE;
        end
      endcase
    end
  end

  // State, forwarding registers and saturating busy-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= 2'd0;
        rem_q[o]   <= 8'd0;
        rr_q[o]    <= 2'd0;
        outp[o]    <= 32'd0;
      end
      out_ram_wr <= '0;
      total_time <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rem_q[o]   <= rem_d[o];
        rr_q[o]    <= rr_d[o];
        outp[o]    <= acc_s[o] ? in_data[src_s[o]] : outp[o];
      end
      out_ram_wr <= acc_s;
      if (clear) begin
        total_time <= '0;
      end else if (busy && (total_time != {CNT_W{1'b1}})) begin
        total_time <= total_time + CNT_W'(1);
      end else begin
        total_time <= total_time;
      end
    end
  end

endmodule

// File: tb/tb_switch_scheduler.sv
// Randomized and directed bench for switch_scheduler: a packet-level reference model
// predicts accepted words into per-output queues that a monitor drains against the DUT.
module tb_switch_scheduler;
  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [3:0][31:0] in_data;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [3:0][31:0] outp;
  logic [3:0]       out_ram_wr;
  logic [31:0]      total_time;
  logic             busy;

  always #5 clk = ~clk;

  switch_scheduler #(.NPORTS(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .outp(outp), .out_ram_wr(out_ram_wr), .total_time(total_time), .busy(busy)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [4][$];
  logic [31:0] src_q [4][$];
  logic [31:0] hold_v [4];
  logic [31:0] exp_total = 32'd0;
  bit          mon_en = 1'b0;
  bit          mon_rst = 1'b0;
  int          lock_own [4];
  int          rem_m [4];
  int          rr_m [4];
  bit          strobe_m [4];
  logic [3:0]  acc_m;
  logic [3:0]  last_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already set; predict, check ready/busy, advance the model
  task automatic cycle(input logic rst, input logic clr);
    bit   owned [4];
    bit   nxt [4];
    bit   busy_m;
    logic [3:0] rdy_m;
    reset = rst;
    clear = clr;
    #1;
    rdy_m  = 4'h0;
    acc_m  = 4'h0;
    busy_m = |in_valid;
    for (int o = 0; o < 4; o++) begin
      busy_m   = busy_m | (lock_own[o] >= 0) | strobe_m[o];
      owned[o] = 1'b0;
      nxt[o]   = 1'b0;
    end
    chk("busy", {31'd0, busy}, {31'd0, busy_m});
    if (rst) begin
      for (int o = 0; o < 4; o++) begin
        lock_own[o] = -1;
        rem_m[o]    = 0;
        rr_m[o]     = 0;
      end
      exp_total = 32'd0;
    end else begin
      for (int o = 0; o < 4; o++) if (lock_own[o] >= 0) owned[lock_own[o]] = 1'b1;
      for (int o = 0; o < 4; o++) begin
        if (lock_own[o] >= 0) begin
          rdy_m[lock_own[o]] = 1'b1;
          if (in_valid[lock_own[o]]) begin
            exp_q[o].push_back(in_data[lock_own[o]]);
            acc_m[lock_own[o]] = 1'b1;
            nxt[o] = 1'b1;
            rem_m[o]--;
            if (rem_m[o] == 0) lock_own[o] = -1;
          end
        end else begin
          for (int k = 0; k < 4; k++) begin
            int i;
            i = (rr_m[o] + k) % 4;
            if (!nxt[o] && in_valid[i] && (in_data[i][1:0] == 2'(o)) && !owned[i]) begin
              nxt[o]   = 1'b1;
              rdy_m[i] = 1'b1;
              acc_m[i] = 1'b1;
              exp_q[o].push_back(in_data[i]);
              rr_m[o] = (i + 1) % 4;
              if (in_data[i][11:4] != 8'd0) begin
                lock_own[o] = i;
                rem_m[o]    = int'(in_data[i][11:4]);
              end
            end
          end
        end
      end
      if (clr) exp_total = 32'd0;
      else if (busy_m && exp_total != 32'hFFFF_FFFF) exp_total = exp_total + 32'd1;
    end
    for (int o = 0; o < 4; o++) strobe_m[o] = nxt[o];
    chk("in_ready", {28'd0, in_ready}, {28'd0, rdy_m});
    last_rdy = in_ready;
    mon_rst  = rst;
    mon_en   = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive(input int n, input logic [3:0] mask, input bit rnd, input bit clr);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 4; i++) begin
        in_valid[i] = (src_q[i].size() > 0) && mask[i] && (!rnd || $urandom_range(3) != 0);
        in_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : $urandom;
      end
      cycle(1'b0, clr);
      for (int i = 0; i < 4; i++) if (acc_m[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic add_pkt(input int i, input int dst, input int len);
    logic [31:0] w;
    w = $urandom;
    w[1:0]  = 2'(dst);
    w[11:4] = 8'(len);
    src_q[i].push_back(w);
    for (int p = 0; p < len; p++) begin
      w = $urandom;
      w[11:8] = 4'h0;
      src_q[i].push_back(w);
    end
  endtask

  // Monitor: every strobe must match the next predicted word; outp holds otherwise
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      for (int o = 0; o < 4; o++) begin
        if (mon_rst) hold_v[o] = 32'd0;
        if (exp_q[o].size() > 0) begin
          hold_v[o] = exp_q[o].pop_front();
          chk($sformatf("out_ram_wr[%0d]", o), {31'd0, out_ram_wr[o]}, 32'd1);
        end else begin
          chk($sformatf("out_ram_wr[%0d]", o), {31'd0, out_ram_wr[o]}, 32'd0);
        end
        chk($sformatf("outp[%0d]", o), outp[o], hold_v[o]);
      end
      chk("total_time", total_time, exp_total);
    end
  end

  initial begin
    logic [3:0] rec [6];
    logic [3:0] want [6];
    want = '{4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8};
    reset = 1'b1;
    clear = 1'b0;
    in_valid = 4'h0;
    in_data = '0;
    for (int o = 0; o < 4; o++) begin
      lock_own[o] = -1;
      rem_m[o] = 0;
      rr_m[o] = 0;
      strobe_m[o] = 1'b0;
      hold_v[o] = 32'd0;
    end
    @(negedge clk);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    // Single word to port 2
    src_q[0].push_back(32'h0000_0002);
    drive(3, 4'hF, 1'b0, 1'b0);

    // Contention on port 1 with zero-length headers
    for (int c = 0; c < 6; c++) begin
      in_valid = 4'b1011;
      for (int i = 0; i < 4; i++) in_data[i] = 32'h0000_0001;
      cycle(1'b0, 1'b0);
      rec[c] = last_rdy;
    end
    for (int c = 0; c < 6; c++) chk($sformatf("rr_grant[%0d]", c), {28'd0, rec[c]}, {28'd0, want[c]});
    drive(2, 4'h0, 1'b0, 1'b0);

    // Packet lock: input 2 owns port 0 while input 1 waits
    src_q[2] = '{32'h0000_0030, 32'h0000_00A1, 32'h0000_00B1, 32'h0000_00C1};
    drive(1, 4'b0100, 1'b0, 1'b0);
    src_q[1].push_back(32'h0000_0000);
    drive(6, 4'b0110, 1'b0, 1'b0);

    // Bubble: owner drops valid for two cycles after the first payload
    src_q[3] = '{32'h0000_0030, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
    src_q[0].push_back(32'h0000_0000);
    drive(2, 4'b1000, 1'b0, 1'b0);
    drive(2, 4'b0001, 1'b0, 1'b0);
    drive(6, 4'b1001, 1'b0, 1'b0);

    // Parallel transfers, then reset mid-packet
    for (int i = 0; i < 4; i++) add_pkt(i, 3 - i, 5);
    drive(3, 4'hF, 1'b0, 1'b0);
    chk("all_strobes", {28'd0, out_ram_wr}, 32'h0000_000F);
    cycle(1'b1, 1'b0);
    chk("rst_strobes", {28'd0, out_ram_wr}, 32'd0);
    chk("rst_total", total_time, 32'd0);
    drive(40, 4'hF, 1'b0, 1'b0);

    // Timer: workload, idle, then clear while busy
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      for (int p = 0; p < 3; p++) add_pkt(i, $urandom_range(3), 0);
    end
    drive(10, 4'hF, 1'b0, 1'b0);
    drive(5, 4'h0, 1'b0, 1'b0);
    add_pkt(0, 1, 0);
    drive(1, 4'hF, 1'b0, 1'b1);
    drive(3, 4'h0, 1'b0, 1'b0);

    // Randomized traffic with occasional reset and clear
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if (src_q[i].size() == 0)
          add_pkt(i, $urandom_range(3), ($urandom_range(3) == 0) ? 0 : $urandom_range(6, 1));
      if ($urandom_range(299) == 0) begin
        for (int i = 0; i < 4; i++) begin
          in_valid[i] = $urandom_range(1);
          in_data[i] = src_q[i][0];
        end
        cycle(1'b1, 1'b0);
      end else begin
        drive(1, 4'hF, 1'b1, ($urandom_range(149) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_scheduler.md
# switch_scheduler

Packet scheduler for the 4-port switch. It sits directly upstream of the output buffer stage and drives that stage's per-port write data (`outp`), write strobes (`out_ram_wr`) and run-time counter (`total_time`). Each input presents packets on a valid/ready stream. Each output port independently round-robin-arbitrates among the inputs whose head packet targets it, then locks to the winner for the whole packet.

## Interface
- `NPORTS`, 4: number of input and output ports; only 4 is supported.
- `CNT_W`, 32: width of `total_time`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous clear of `total_time` only.
- `in_data[4]`  in  32  input word.
  - Header word: bits [1:0] give the destination port; bits [11:4] give the payload length L (0..255).
- `in_valid[4]`  in  1  input word valid.
- `in_ready[4]`  out  1  input word accepted this cycle when high with `in_valid`.
- `outp[4]`  out  32  word forwarded to the output buffer.
- `out_ram_wr[4]`  out  1  `outp[o]` is a new word this cycle.
- `total_time`  out  CNT_W  count of busy cycles.
- `busy`  out  1  scheduler has work in flight.

## Operation
- A packet is one header word followed by L payload words. The header is forwarded unchanged.
- Per output o: FSM with states IDLE and BUSY, an owner register (2 bits), a remaining count (8 bits), and a round-robin pointer rr[o] (2 bits).
- IDLE: the candidates are inputs i with all of the following:
  - `in_valid[i]` is high;
  - `in_data[i][1:0]`==o;
  - input i is not owned by any BUSY output.
- IDLE arbitration: the winner is the first candidate searching from rr[o] upward, modulo 4.
  - `in_ready[winner]` is asserted and the header is accepted in the same cycle.
  - rr[o] is set to winner+1 mod 4.
  - If L==0, remain IDLE. Otherwise go to BUSY with owner=winner and remaining=L.
- BUSY: `in_ready[owner]` = 1.
  - Each accepted word decrements remaining.
  - Acceptance with remaining==1 returns to IDLE.
  - Payload bits [1:0] are never decoded. An owned input is invisible to every other output's arbitration.
- `in_ready[i]` = 0 whenever input i is neither the IDLE winner nor a BUSY owner.
- Outputs operate concurrently. Four distinct input→output pairs may transfer in the same cycle.
- Forwarding registers, per output o:
  - `out_ram_wr[o]` <= (a word was accepted for o);
  - `outp[o]` <= that word;
  - `outp[o]` holds its value when nothing was accepted.
- busy = (any `in_valid`) | (any output BUSY) | (any `out_ram_wr`).
- `total_time`:
  - `clear` has priority: zero;
  - otherwise it increments by 1 each cycle that busy is high;
  - it saturates at 2^CNT_W-1.
- Reset values: all FSMs IDLE, owners 0, remaining 0, rr 0, `outp` all 0, `out_ram_wr` 0, `total_time` 0. `in_ready` is 0 during reset.
- Reset mid-packet: the partial packet is abandoned and is not resumed. Remaining input words are treated as new headers.

## Timing
- `in_ready` is combinational from FSM state, owners, rr, `in_valid` and `in_data[1:0]`. Upstream must not make `in_valid` depend on `in_ready`.
- Latency: a word accepted in cycle t appears on `outp`/`out_ram_wr` in cycle t+1, for exactly one cycle of strobe.
- Back-to-back packets on one output need no bubble:
  - the return to IDLE takes effect at the edge after the last word;
  - the next header can be accepted in the following cycle;
  - a packet of L words therefore occupies L+1 consecutive cycles at full rate.
- When the owner's `in_valid` is low while BUSY:
  - `out_ram_wr[o]` = 0 one cycle later;
  - remaining is unchanged;
  - the lock persists indefinitely.
- A header with L==0 releases the output in the same cycle. The output can re-arbitrate on the very next cycle.
- `busy` is combinational. `total_time` updates on the edge following the busy cycle.

## Test plan
- **Single word:** after reset, input 0 presents 0x0000_0002 for one cycle.
  - `in_ready[0]`=1 in that cycle.
  - In the next cycle `outp[2]`=0x0000_0002 and `out_ram_wr[2]`=1.
  - All other strobes stay 0.
- **Contention:** inputs 0, 1 and 3 hold headers to port 1 with L=0, each re-presented after acceptance.
  - Grants occur in order 0, 1, 3, 0, … on consecutive cycles.
  - rr[1] reads 1, 2, 0 after each of the first three grants.
- **Packet lock:** input 2 sends header 0x0000_0030 (port 0, L=3), then payloads 0xA1, 0xB1, 0xC1. Input 1 concurrently holds a port-0 header.
  - `outp[0]` shows 0x30, 0xA1, 0xB1, 0xC1 on four consecutive cycles.
  - `out_ram_wr[1]` stays 0.
  - Input 1's header is accepted in the cycle after 0xC1 is accepted.
- **Bubble:** during an L=3 packet, drop the owner's `in_valid` for 2 cycles after the first payload.
  - `out_ram_wr` shows 2 low cycles.
  - All 4 words are still delivered in order.
  - No other input gains the port.
- **Parallel and reset:** inputs 0–3 target ports 3, 2, 1, 0 with L=5. Assert `reset` after the second payload.
  - All four strobes are 1 simultaneously before reset.
  - After reset, every output is 0 and `total_time`=0.
  - The next words presented are arbitrated as headers.
- **Timer:** run a 10-cycle workload, then idle 5 cycles.
  - `total_time` equals the count of busy cycles and holds during idle.
  - `clear` pulsed together with busy yields 0.
